// File: rtl/project_led_if.sv
// Avalon-MM slave bus bundle for project_led: word address, write strobe and registered read data.
interface project_led_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/project_led.sv
// LED output port with DATA/OUTSET/OUTCLEAR registers and an optional blink engine.
// Define PROJECT_LED_BLINK_EN to build in MASK, PERIOD and the blink counter.
module project_led #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned RESET_VALUE = 0,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  project_led_if.slave     bus,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [WIDTH-1:0] DataRst = WIDTH'(RESET_VALUE);

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      rdata_q, rdata_d;

  assign wr    = bus.chipselect && !bus.write_n;
  assign wdata = bus.writedata[WIDTH-1:0];

  always_comb begin
    data_d = data_q;
    if (wr) begin
      case (bus.address)
        3'd0:    data_d = wdata;
        3'd2:    data_d = data_q | wdata;
        3'd3:    data_d = data_q & ~wdata;
        default: data_d = data_q;
      endcase
    end
  end

`ifdef PROJECT_LED_BLINK_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      period_q, period_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [31:0]      period_eff;

  always_comb begin
    mask_d     = mask_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    period_eff = (period_q == 32'd0) ? 32'd1 : period_q;
    // A PERIOD write restarts the count and suppresses the toggle on that edge.
    if (wr && bus.address == 3'd4) begin
      period_d = bus.writedata;
      cnt_d    = '0;
    end else if (cnt_q >= period_eff - 32'd1) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
    if (wr && bus.address == 3'd1) begin
      mask_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q   <= '0;
      period_q <= BLINK_DIV;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (bus.address)
      3'd0:    rdata_d = 32'(data_q);
      3'd1:    rdata_d = 32'(mask_q);
      3'd4:    rdata_d = period_q;
      default: rdata_d = '0;
    endcase
  end

  assign out_port = data_q ^ (mask_q & {WIDTH{phase_q}});
`else
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    rdata_d = '0;
    if (bus.address == 3'd0) begin
      rdata_d = 32'(data_q);
    end
  end

  assign out_port = data_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= DataRst;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_project_led.sv
// Scoreboard bench for project_led: a cycle model pushes expected readdata/out_port per edge,
// a monitor pops and compares after each rising edge or on an explicit mid-cycle sample.
module tb_project_led;
  localparam int unsigned Width      = 8;
  localparam int unsigned ResetValue = 32'h3c;
  localparam int unsigned BlinkDiv   = 5;
`ifdef PROJECT_LED_BLINK_EN
  localparam bit BlinkEn = 1'b1;
`else
  localparam bit BlinkEn = 1'b0;
`endif
  localparam logic [Width-1:0] RstOut = Width'(ResetValue);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             sample_now = 1'b0;
  logic [Width-1:0] out_port;

  project_led_if bus ();

  project_led #(
    .WIDTH      (Width),
    .RESET_VALUE(ResetValue),
    .BLINK_DIV  (BlinkDiv)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      rd;
    logic [Width-1:0] out;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference state: phase is derived from edges elapsed since the last restart point.
  logic [Width-1:0] m_data;
  logic [Width-1:0] m_mask;
  logic [31:0]      m_period;
  logic             m_base;
  longint           m_n;

  function automatic logic m_phase();
    longint eff;
    eff = (m_period == 32'd0) ? 64'd1 : longint'(m_period);
    return m_base ^ (((m_n / eff) % 2) == 1);
  endfunction

  task automatic model_reset();
    m_data   = RstOut;
    m_mask   = '0;
    m_period = BlinkDiv;
    m_base   = 1'b0;
    m_n      = 0;
  endtask

  task automatic model_step(input logic [2:0] a, input logic cs, input logic wn,
                            input logic [31:0] wd);
    exp_t e;
    logic wr;
    logic ph;
    wr = cs && !wn;
    case (a)
      3'd0:    e.rd = 32'(m_data);
      3'd1:    e.rd = BlinkEn ? 32'(m_mask) : 32'd0;
      3'd4:    e.rd = BlinkEn ? m_period : 32'd0;
      default: e.rd = 32'd0;
    endcase
    if (BlinkEn) begin
      if (wr && a == 3'd4) begin
        m_base   = m_phase();
        m_n      = 0;
        m_period = wd;
      end else begin
        m_n = m_n + 1;
      end
      if (wr && a == 3'd1) m_mask = wd[Width-1:0];
    end
    if (wr) begin
      case (a)
        3'd0:    m_data = wd[Width-1:0];
        3'd2:    m_data = m_data | wd[Width-1:0];
        3'd3:    m_data = m_data & ~wd[Width-1:0];
        default: ;
      endcase
    end
    ph    = BlinkEn ? m_phase() : 1'b0;
    e.out = m_data ^ (m_mask & {Width{ph}});
    exp_q.push_back(e);
  endtask

  task automatic bus_cycle(input logic [2:0] a, input logic cs, input logic wn,
                           input logic [31:0] wd);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.writedata  = wd;
    model_step(a, cs, wn, wd);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
    bus_cycle(a, 1'b1, 1'b0, wd);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    bus_cycle(a, 1'b0, 1'b1, $urandom);
  endtask

  // Called mid-cycle while reset is low: the outputs must already show the reset state.
  task automatic reset_check();
    exp_t e;
    e.rd  = 32'd0;
    e.out = RstOut;
    exp_q.push_back(e);
    #1 sample_now = 1'b1;
    #1 sample_now = 1'b0;
    #2;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge sample_now);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.readdata !== e.rd) begin
          failures++;
          $display("FAIL readdata @%0t addr=%0d: got %h expected %h", $time, bus.address,
                   bus.readdata, e.rd);
        end
        checks++;
        if (out_port !== e.out) begin
          failures++;
          $display("FAIL out_port @%0t: got %h expected %h", $time, out_port, e.out);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    model_reset();
    #12;
    reset_check();
    @(posedge clk);
    #2 reset_n = 1'b1;

    for (int a = 0; a < 8; a++) rd_reg(3'(a));

    wr_reg(3'd0, 32'h1a5);
    rd_reg(3'd0);
    rd_reg(3'd0);

    wr_reg(3'd0, 32'h0f);
    wr_reg(3'd2, 32'hc0);
    wr_reg(3'd3, 32'h03);
    rd_reg(3'd2);
    rd_reg(3'd3);
    rd_reg(3'd0);

    wr_reg(3'd0, 32'h00);
    wr_reg(3'd1, 32'h01);
    wr_reg(3'd4, 32'd3);
    repeat (12) rd_reg(3'd4);
    wr_reg(3'd4, 32'd0);
    repeat (6) rd_reg(3'd1);

    // DATA writes landing on toggle edges
    wr_reg(3'd4, 32'd2);
    wr_reg(3'd1, 32'hf0);
    for (int i = 0; i < 8; i++) wr_reg(3'd0, $urandom);

    wr_reg(3'd1, 32'hff);
    wr_reg(3'd4, 32'd4);
    for (int k = 0; k < 20 && !m_phase(); k++) rd_reg(3'd0);
    wr_reg(3'd1, 32'h0f);
    repeat (3) rd_reg(3'd0);

    // Asynchronous reset in the middle of a blink with PHASE=1
    wr_reg(3'd0, 32'h81);
    wr_reg(3'd1, 32'hff);
    wr_reg(3'd4, 32'd3);
    for (int k = 0; k < 20 && !m_phase(); k++) rd_reg(3'd0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    bus.chipselect = 1'b0;
    model_reset();
    reset_check();
    @(posedge clk);
    #2 reset_n = 1'b1;
    wr_reg(3'd1, 32'h01);
    repeat (8) rd_reg(3'd4);

    for (int i = 0; i < 1500; i++) begin
      logic [2:0]  a;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd4 && $urandom_range(0, 7) != 0) wd = $urandom_range(0, 5);
      bus_cycle(a, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), wd);
    end

    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/project_led.md
PROJECT_LED -- requirements
Module: project_led

Interface
- REQ-001: The block SHALL expose the following parameters, one per line (name, default, meaning):
  - WIDTH, 8, number of output bits (1..32).
  - RESET_VALUE, 0, value loaded into DATA at reset.
  - BLINK_DIV, 25000000, reset value of the PERIOD register.
- REQ-002: The block SHALL have one clock and an asynchronous, active-low reset, with these ports (name, direction, width, meaning):
  - clk, input, 1, sole clock; all state updates on its rising edge.
  - reset_n, input, 1, asynchronous active-low reset.
  - address, input, 3, Avalon-MM word address.
  - chipselect, input, 1, slave select.
  - write_n, input, 1, active-low write strobe.
  - writedata, input, 32, write data.
  - readdata, output, 32, registered read data.
  - out_port, output, WIDTH, driven pins.

Function
- REQ-003: A write SHALL be accepted on any clk edge where chipselect=1 and write_n=0; there are no wait states and no back-pressure.
- REQ-004: The register map SHALL be:
  - 0 DATA: R/W.
  - 1 MASK: R/W, the blink mask.
  - 2 OUTSET: W, reads 0.
  - 3 OUTCLEAR: W, reads 0.
  - 4 PERIOD: R/W, 32 bits.
  - 5-7: reserved; writes are ignored and reads return 0.
- REQ-005: A write to DATA SHALL load writedata[WIDTH-1:0]; bits above WIDTH are ignored.
- REQ-006: A write to OUTSET SHALL perform DATA <= DATA | writedata[WIDTH-1:0].
- REQ-007: A write to OUTCLEAR SHALL perform DATA <= DATA & ~writedata[WIDTH-1:0].
- REQ-008: readdata SHALL be updated on every clk edge from the current address, with 1-cycle read latency, zero-extended to 32 bits and independent of chipselect.
- REQ-009: A read of DATA SHALL return the DATA register, not the blinked out_port value.
- REQ-010: The blink engine SHALL contain a 32-bit counter CNT and a 1-bit PHASE.
- REQ-011: On each clk edge, if CNT >= max(PERIOD,1)-1 then CNT <= 0 and PHASE toggles; otherwise CNT <= CNT+1.
- REQ-012: PERIOD=0 SHALL behave as PERIOD=1, so PHASE toggles every cycle.
- REQ-013: A write to PERIOD SHALL load the new value and force CNT <= 0 on the same edge, with no PHASE toggle on that edge.
- REQ-014: out_port SHALL equal DATA ^ (MASK & {WIDTH{PHASE}}), formed combinationally from flops only, with no combinational path from bus inputs.
- REQ-015: Any register write SHALL become visible on out_port in the cycle after the accepting edge.
- REQ-016: When a DATA/OUTSET/OUTCLEAR write coincides with a PHASE toggle, both SHALL take effect on the same edge; the write updates DATA and the toggle updates PHASE, so they never conflict.
- REQ-017: A MASK bit cleared while PHASE=1 SHALL return that bit to its DATA value on the next cycle.

Reset
- REQ-018: While reset_n=0, the block SHALL hold DATA=RESET_VALUE, MASK=0, PERIOD=BLINK_DIV, CNT=0, PHASE=0, readdata=0 and out_port=RESET_VALUE.
- REQ-019: Reset assertion mid-operation (including mid-blink) SHALL take effect immediately and asynchronously.
- REQ-020: On reset deassertion, the first active edge SHALL behave as a normal cycle.

Configuration
- REQ-021: The macro PROJECT_LED_BLINK_EN SHALL compile the blink engine in; when it is defined, behaviour is as specified in REQ-010 to REQ-017.
- REQ-022: When PROJECT_LED_BLINK_EN is undefined, MASK, PERIOD, CNT and PHASE SHALL be absent; addresses 1 and 4 then behave as reserved, and out_port = DATA.

Verification
- REQ-023: Reset, then read addresses 0-7 -> readdata = RESET_VALUE at address 0 and BLINK_DIV at address 4 (0 at 4 without the macro), all other addresses 0; out_port = RESET_VALUE.
- REQ-024: Write DATA=0x1A5 with WIDTH=8 -> read DATA returns 0xA5 one cycle after the address is presented; out_port=0xA5 on the cycle after the write.
- REQ-025: Starting from DATA=0x0F, write OUTSET=0xC0 then OUTCLEAR=0x03 -> DATA goes 0xCF then 0xCC; OUTSET and OUTCLEAR read 0.
- REQ-026: PERIOD=3, MASK=0x01, DATA=0x00 -> out_port[0] toggles every 3 cycles (0,0,0,1,1,1,...); writing PERIOD=0 -> out_port[0] toggles every cycle.
- REQ-027: Assert reset_n=0 mid-blink with PHASE=1 -> out_port returns to RESET_VALUE within the same cycle, asynchronously, and CNT=0.
- REQ-028: Write DATA while PHASE toggles on the same edge -> out_port the next cycle = new DATA ^ (MASK & new PHASE).
